// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer for the two-wide front end: owns the fetch PC, issues aligned
// 64-bit imem requests, buffers one response block and squashes on redirects.
module fetch_seq_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h1eceb000,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  imem_req,
  output logic [31:0]           imem_addr,
  input  logic                  imem_resp,
  input  logic [63:0]           imem_rdata,
  output logic                  out_valid,
  output logic [31:0]           out_pc,
  output logic [1:0]            out_slot_valid,
  output logic [63:0]           out_inst,
  input  logic                  out_ready,
  output logic [DROP_CNT_W-1:0] drop_count
);

  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             redir_pc, next_pc;
  logic                    buf_valid_q, buf_valid_d;
  logic [31:0]             buf_pc_q;
  logic [63:0]             buf_inst_q;
  logic                    capture, clear_buf, drop;
  logic [DROP_CNT_W-1:0]   drop_q;

  assign redir_pc = redirect_pc & 32'hffff_fffc;
  assign next_pc  = {pc_q[31:3] + 29'd1, 3'b000};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    capture     = 1'b0;
    clear_buf   = 1'b0;
    drop        = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = {pc_q[31:3], 3'b000};
    case (state_q)
      REQ: begin
        if (redirect_valid) begin
          pc_d = redir_pc;
        end else begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          if (redirect_valid) begin
            drop    = 1'b1;
            pc_d    = redir_pc;
            state_d = REQ;
          end else begin
            capture     = 1'b1;
            buf_valid_d = 1'b1;
            state_d     = HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = redir_pc;
          state_d = DRAIN;
        end
      end
      HOLD: begin
        // The consuming handshake requests the following block in the same cycle.
        imem_addr = next_pc;
        if (redirect_valid) begin
          clear_buf   = 1'b1;
          buf_valid_d = 1'b0;
          pc_d        = redir_pc;
          state_d     = REQ;
        end else if (out_ready) begin
          imem_req    = 1'b1;
          buf_valid_d = 1'b0;
          pc_d        = next_pc;
          state_d     = WAIT;
        end
      end
      DRAIN: begin
        if (imem_resp) begin
          drop = 1'b1;
          if (redirect_valid) begin
            pc_d    = redir_pc;
            state_d = REQ;
          end else begin
            imem_req = 1'b1;
            state_d  = WAIT;
          end
        end else if (redirect_valid) begin
          pc_d = redir_pc;
        end
      end
      default: state_d = REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      if (capture) begin
        buf_pc_q   <= pc_q;
        buf_inst_q <= imem_rdata;
      end else if (clear_buf) begin
        buf_pc_q   <= '0;
        buf_inst_q <= '0;
      end
      if (drop && (drop_q != '1)) begin
        drop_q <= drop_q + DROP_CNT_W'(1);
      end
    end
  end

  assign out_valid      = buf_valid_q;
  assign out_pc         = buf_pc_q;
  assign out_inst       = buf_inst_q;
  assign out_slot_valid = buf_valid_q ? (buf_pc_q[2] ? 2'b10 : 2'b11) : 2'b00;
  assign drop_count     = drop_q;

endmodule
